// File: rtl/mtpsa_digest_extract.sv
// mtpsa_digest_extract
//   Splits the switch-wrapper output into a packet stream and a digest stream.
//   The first beat of every packet (SOP) is classified: metadata bit 32 drops
//   the whole packet, metadata bit 40 requests that the 256-bit digest carried
//   in tuser[303:48] be queued for the CPU path. Forwarded beats go through a
//   one-entry output register; digests go through a small FIFO that discards
//   new digests on overflow instead of stalling the packet path.
//
// Ports
//   axis_aclk, axis_reset   clock, asynchronous active-high reset
//   s_axis_*                packet input (tuser = {digest, metadata[47:0]})
//   m_axis_*                packet output (tuser = {zeros, metadata[47:0]})
//   dig_tdata/tvalid/tready digest stream, FIFO head
//   pkt_cnt                 forwarded packets
//   drop_cnt                dropped packets
//   dig_ovf_cnt             digests discarded because the FIFO was full
module mtpsa_digest_extract #(
    parameter int C_AXIS_DATA_WIDTH    = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 304,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int DIGEST_WIDTH         = 256,
    parameter int DIG_FIFO_DEPTH       = 4
) (
    input  logic                              axis_aclk,
    input  logic                              axis_reset,
    input  logic [C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    output logic [DIGEST_WIDTH-1:0]           dig_tdata,
    output logic                              dig_tvalid,
    input  logic                              dig_tready,
    output logic [31:0]                       pkt_cnt,
    output logic [31:0]                       drop_cnt,
    output logic [31:0]                       dig_ovf_cnt
);

    localparam int META_W   = 48;
    localparam int DROP_BIT = 32;
    localparam int DIG_BIT  = 40;
    localparam int AW       = (DIG_FIFO_DEPTH > 1) ? $clog2(DIG_FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {SOP, FWD, DROP} state_t;

    state_t state_q, state_d;

    logic                            mv_q;
    logic [C_AXIS_DATA_WIDTH-1:0]    mdata_q;
    logic [C_AXIS_DATA_WIDTH/8-1:0]  mkeep_q;
    logic [C_M_AXIS_TUSER_WIDTH-1:0] muser_q, muser_d;
    logic                            mlast_q;

    logic [DIGEST_WIDTH-1:0] mem_q [DIG_FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [AW:0]             cnt_q, cnt_d;

    logic [31:0] pkt_cnt_q, drop_cnt_q, ovf_cnt_q;

    logic in_sop, sop_drop, accept, fwd_beat;
    logic push, pop, full, empty, push_ok, ovf;

    // Drop classification looks at the beat currently presented so that a
    // dropped SOP beat is accepted even while the output register is stalled.
    assign in_sop   = (state_q == SOP);
    assign sop_drop = in_sop & s_axis_tuser[DROP_BIT];

    assign s_axis_tready = ~axis_reset &
                           ((state_q == DROP) | sop_drop | ~mv_q | m_axis_tready);
    assign accept   = s_axis_tvalid & s_axis_tready;
    assign fwd_beat = accept & ((state_q == FWD) | (in_sop & ~s_axis_tuser[DROP_BIT]));

    // Packet FSM
    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (s_axis_tlast)
                state_d = SOP;
            else if (in_sop)
                state_d = s_axis_tuser[DROP_BIT] ? DROP : FWD;
        end
    end

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) state_q <= SOP;
        else            state_q <= state_d;
    end

    // Output register: load on a forwarded beat, otherwise drain when taken.
    always_comb begin
        muser_d = '0;
        muser_d[META_W-1:0] = s_axis_tuser[META_W-1:0];
    end

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            mv_q    <= 1'b0;
            mdata_q <= '0;
            mkeep_q <= '0;
            muser_q <= '0;
            mlast_q <= 1'b0;
        end else if (fwd_beat) begin
            mv_q    <= 1'b1;
            mdata_q <= s_axis_tdata;
            mkeep_q <= s_axis_tkeep;
            muser_q <= muser_d;
            mlast_q <= s_axis_tlast;
        end else if (m_axis_tready) begin
            mv_q    <= 1'b0;
        end
    end

    assign m_axis_tvalid = mv_q;
    assign m_axis_tdata  = mdata_q;
    assign m_axis_tkeep  = mkeep_q;
    assign m_axis_tuser  = muser_q;
    assign m_axis_tlast  = mlast_q;

    // Digest FIFO. A pop in the same cycle frees the slot for a push to a
    // full FIFO, so overflow only counts when nothing leaves.
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DIG_FIFO_DEPTH));
    assign pop     = ~empty & dig_tready;
    assign push    = accept & in_sop & s_axis_tuser[DIG_BIT];
    assign push_ok = push & (~full | pop);
    assign ovf     = push & full & ~pop;

    always_comb begin
        cnt_d = cnt_q;
        if (push_ok & ~pop)
            cnt_d = cnt_q + (AW+1)'(1);
        else if (pop & ~push_ok)
            cnt_d = cnt_q - (AW+1)'(1);
    end

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            for (int i = 0; i < DIG_FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= s_axis_tuser[META_W +: DIGEST_WIDTH];
        end
    end

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push_ok)
                wr_ptr_q <= (wr_ptr_q == AW'(DIG_FIFO_DEPTH-1)) ? '0 : wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= (rd_ptr_q == AW'(DIG_FIFO_DEPTH-1)) ? '0 : rd_ptr_q + AW'(1);
        end
    end

    assign dig_tdata  = mem_q[rd_ptr_q];
    assign dig_tvalid = ~empty;

    // Statistics
    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
            ovf_cnt_q  <= '0;
        end else begin
            if (accept & in_sop & ~s_axis_tuser[DROP_BIT]) pkt_cnt_q  <= pkt_cnt_q + 32'd1;
            if (accept & sop_drop)                         drop_cnt_q <= drop_cnt_q + 32'd1;
            if (ovf)                                       ovf_cnt_q  <= ovf_cnt_q + 32'd1;
        end
    end

    assign pkt_cnt     = pkt_cnt_q;
    assign drop_cnt    = drop_cnt_q;
    assign dig_ovf_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_mtpsa_digest_extract.sv
// Directed bench for mtpsa_digest_extract. Inputs change on the falling
// edge; outputs are sampled on the falling edge (or 1 ns after it for the
// combinational ready).
module tb_mtpsa_digest_extract;

    logic          clk, rst;
    logic [255:0]  s_tdata;
    logic [31:0]   s_tkeep;
    logic [303:0]  s_tuser;
    logic          s_tvalid, s_tlast, s_tready;
    logic [255:0]  m_tdata;
    logic [31:0]   m_tkeep;
    logic [127:0]  m_tuser;
    logic          m_tvalid, m_tlast, m_tready;
    logic [255:0]  dig_tdata;
    logic          dig_tvalid, dig_tready;
    logic [31:0]   pkt_cnt, drop_cnt, ovf_cnt;

    int total = 0;
    int bad   = 0;

    localparam logic [255:0] DIG_A5 = {32{8'hA5}};
    localparam logic [255:0] DIG_3C = {32{8'h3C}};

    mtpsa_digest_extract dut (
        .axis_aclk     (clk),
        .axis_reset    (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .dig_tdata     (dig_tdata),
        .dig_tvalid    (dig_tvalid),
        .dig_tready    (dig_tready),
        .pkt_cnt       (pkt_cnt),
        .drop_cnt      (drop_cnt),
        .dig_ovf_cnt   (ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL reset_s_tready got=%b exp=0", s_tready); end
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_m_tvalid got=%b exp=0", m_tvalid); end
        total++; if (dig_tvalid !== 1'b0) begin bad++; $display("FAIL reset_dig_tvalid got=%b exp=0", dig_tvalid); end
        total++; if ({pkt_cnt, drop_cnt, ovf_cnt} !== 96'h0) begin bad++; $display("FAIL reset_counters got=%h/%h/%h exp=0", pkt_cnt, drop_cnt, ovf_cnt); end
        total++; if (m_tdata !== 256'h0 || m_tuser !== 128'h0 || m_tlast !== 1'b0) begin bad++; $display("FAIL reset_m_data got=%h exp=0", m_tdata); end
        total++; if (dig_tdata !== 256'h0) begin bad++; $display("FAIL reset_dig_tdata got=%h exp=0", dig_tdata); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // 3-beat forwarded packet with digest request
    task automatic test_forward;
        logic [47:0]  meta;
        logic [255:0] dat [3];
        meta   = 48'h0100_0000_0AB1;
        dat[0] = {8{32'h1111_0000}};
        dat[1] = {8{32'h2222_0001}};
        dat[2] = {8{32'h3333_0002}};
        m_tready = 1'b1; dig_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_tvalid = 1'b1; s_tdata = dat[i]; s_tuser = {DIG_A5, meta}; s_tlast = (i == 2);
            #1;
            total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL fwd_s_tready beat=%0d got=%b exp=1", i, s_tready); end
            @(negedge clk);
            total++;
            if (m_tvalid !== 1'b1 || m_tdata !== dat[i] || m_tlast !== (i == 2) || m_tkeep !== 32'hFFFF_FFFF) begin
                bad++; $display("FAIL fwd_beat beat=%0d got v=%b d=%h l=%b exp v=1 d=%h", i, m_tvalid, m_tdata, m_tlast, dat[i]);
            end
            total++; if (m_tuser !== {80'h0, meta}) begin bad++; $display("FAIL fwd_tuser beat=%0d got=%h exp=%h", i, m_tuser, {80'h0, meta}); end
            if (i == 0) begin
                total++; if (dig_tvalid !== 1'b1) begin bad++; $display("FAIL fwd_dig_next_cycle got=%b exp=1", dig_tvalid); end
            end
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        @(negedge clk);
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL fwd_m_idle got=%b exp=0", m_tvalid); end
        total++; if (dig_tvalid !== 1'b1 || dig_tdata !== DIG_A5) begin bad++; $display("FAIL fwd_digest got v=%b d=%h exp=%h", dig_tvalid, dig_tdata, DIG_A5); end
        total++; if (pkt_cnt !== 32'd1 || drop_cnt !== 32'd0) begin bad++; $display("FAIL fwd_counts got pkt=%0d drop=%0d exp 1/0", pkt_cnt, drop_cnt); end
        dig_tready = 1'b1;
        @(negedge clk);
        dig_tready = 1'b0;
        total++; if (dig_tvalid !== 1'b0) begin bad++; $display("FAIL fwd_dig_pop got=%b exp=0", dig_tvalid); end
    endtask

    // 2-beat dropped packet that still carries a digest
    task automatic test_drop;
        m_tready = 1'b1; dig_tready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_tvalid = 1'b1; s_tdata = {8{32'hDEAD_0000 + 32'(i)}};
            s_tuser = {DIG_3C, 48'h0101_0000_0000}; s_tlast = (i == 1);
            #1;
            total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL drop_s_tready beat=%0d got=%b exp=1", i, s_tready); end
            @(negedge clk);
            total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL drop_m_tvalid beat=%0d got=%b exp=0", i, m_tvalid); end
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        total++; if (drop_cnt !== 32'd1 || pkt_cnt !== 32'd1) begin bad++; $display("FAIL drop_counts got drop=%0d pkt=%0d exp 1/1", drop_cnt, pkt_cnt); end
        total++; if (dig_tvalid !== 1'b1 || dig_tdata !== DIG_3C) begin bad++; $display("FAIL drop_digest got v=%b d=%h exp=%h", dig_tvalid, dig_tdata, DIG_3C); end
        dig_tready = 1'b1;
        @(negedge clk);
        dig_tready = 1'b0;
        total++; if (dig_tvalid !== 1'b0) begin bad++; $display("FAIL drop_dig_pop got=%b exp=0", dig_tvalid); end
    endtask

    // Six single-beat digests into a 4-deep FIFO, then push+pop while full
    task automatic test_overflow;
        logic [255:0] exp_q [4];
        m_tready = 1'b1; dig_tready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_tvalid = 1'b1; s_tdata = 256'(32'hBEEF_0000 + 32'(i));
            s_tuser = {256'(i + 1), 48'h0100_0000_0000}; s_tlast = 1'b1;
            @(negedge clk);
            total++; if (m_tvalid !== 1'b1 || m_tdata !== 256'(32'hBEEF_0000 + 32'(i))) begin
                bad++; $display("FAIL ovf_fwd beat=%0d got v=%b d=%h", i, m_tvalid, m_tdata);
            end
        end
        s_tvalid = 1'b0;
        total++; if (ovf_cnt !== 32'd2) begin bad++; $display("FAIL ovf_count got=%0d exp=2", ovf_cnt); end
        total++; if (pkt_cnt !== 32'd7) begin bad++; $display("FAIL ovf_pkt_cnt got=%0d exp=7", pkt_cnt); end
        total++; if (dig_tvalid !== 1'b1 || dig_tdata !== 256'd1) begin bad++; $display("FAIL ovf_head got v=%b d=%h exp=1", dig_tvalid, dig_tdata); end
        // push while full but popping: no overflow
        s_tvalid = 1'b1; s_tuser = {256'd7, 48'h0100_0000_0000}; s_tdata = 256'h77; dig_tready = 1'b1;
        @(negedge clk);
        s_tvalid = 1'b0;
        total++; if (ovf_cnt !== 32'd2 || pkt_cnt !== 32'd8) begin bad++; $display("FAIL ovf_push_pop got ovf=%0d pkt=%0d exp 2/8", ovf_cnt, pkt_cnt); end
        exp_q[0] = 256'd2; exp_q[1] = 256'd3; exp_q[2] = 256'd4; exp_q[3] = 256'd7;
        for (int k = 0; k < 4; k++) begin
            total++; if (dig_tvalid !== 1'b1 || dig_tdata !== exp_q[k]) begin
                bad++; $display("FAIL ovf_drain idx=%0d got v=%b d=%h exp=%h", k, dig_tvalid, dig_tdata, exp_q[k]);
            end
            @(negedge clk);
        end
        total++; if (dig_tvalid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b exp=0", dig_tvalid); end
        dig_tready = 1'b0;
    endtask

    // 4-beat packet with m_axis_tready toggling every cycle
    task automatic test_stall;
        logic [255:0] sd [4];
        int in_idx, out_idx;
        in_idx = 0; out_idx = 0;
        for (int k = 0; k < 4; k++) sd[k] = {8{32'hC0DE_0000 + 32'(k)}};
        dig_tready = 1'b1;
        for (int c = 0; c < 40 && out_idx < 4; c++) begin
            m_tready = c[0];
            if (in_idx < 4) begin
                s_tvalid = 1'b1; s_tdata = sd[in_idx]; s_tlast = (in_idx == 3);
                s_tuser = {256'h0, 48'h0000_0000_0055};
            end else begin
                s_tvalid = 1'b0; s_tlast = 1'b0;
            end
            #1;
            if (m_tvalid && !m_tready) begin
                total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL stall_s_tready cyc=%0d got=%b exp=0", c, s_tready); end
            end else begin
                total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL stall_s_tready_free cyc=%0d got=%b exp=1", c, s_tready); end
            end
            if (m_tvalid) begin
                total++; if (m_tdata !== sd[out_idx] || m_tlast !== (out_idx == 3)) begin
                    bad++; $display("FAIL stall_data cyc=%0d got=%h exp=%h", c, m_tdata, sd[out_idx]);
                end
                if (m_tready) out_idx++;
            end
            if (s_tvalid && s_tready) in_idx++;
            @(negedge clk);
        end
        s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
        total++; if (out_idx != 4) begin bad++; $display("FAIL stall_beats got=%0d exp=4", out_idx); end
        total++; if (pkt_cnt !== 32'd9) begin bad++; $display("FAIL stall_pkt_cnt got=%0d exp=9", pkt_cnt); end
        dig_tready = 1'b0;
        @(negedge clk);
    endtask

    // Reset after beat 2 of a 4-beat packet
    task automatic test_reset_mid;
        m_tready = 1'b1; dig_tready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_tvalid = 1'b1; s_tdata = 256'(i + 32'h50); s_tlast = 1'b0;
            s_tuser = {DIG_A5, 48'h0100_0000_0000};
            @(negedge clk);
        end
        total++; if (dig_tvalid !== 1'b1 || pkt_cnt !== 32'd10) begin bad++; $display("FAIL mid_pre got v=%b pkt=%0d exp 1/10", dig_tvalid, pkt_cnt); end
        s_tvalid = 1'b0;
        rst = 1'b1;
        #1;
        total++; if ({pkt_cnt, drop_cnt, ovf_cnt} !== 96'h0) begin bad++; $display("FAIL mid_counters got=%h/%h/%h exp=0", pkt_cnt, drop_cnt, ovf_cnt); end
        total++; if (dig_tvalid !== 1'b0 || m_tvalid !== 1'b0) begin bad++; $display("FAIL mid_valids got dig=%b m=%b exp=0/0", dig_tvalid, m_tvalid); end
        total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL mid_s_tready got=%b exp=0", s_tready); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        // Next beat must be classified as SOP: drop bit set -> dropped
        s_tvalid = 1'b1; s_tdata = 256'h99; s_tlast = 1'b1; s_tuser = {256'h0, 48'h0001_0000_0000};
        @(negedge clk);
        total++; if (m_tvalid !== 1'b0 || drop_cnt !== 32'd1) begin bad++; $display("FAIL mid_sop_drop got m=%b drop=%0d exp 0/1", m_tvalid, drop_cnt); end
        s_tdata = 256'hAB; s_tuser = {256'h0, 48'h0000_0000_0001};
        @(negedge clk);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        total++; if (m_tvalid !== 1'b1 || m_tdata !== 256'hAB || pkt_cnt !== 32'd1) begin
            bad++; $display("FAIL mid_sop_fwd got m=%b d=%h pkt=%0d exp 1/ab/1", m_tvalid, m_tdata, pkt_cnt);
        end
        @(negedge clk);
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1;
        s_tdata = '0; s_tkeep = '1; s_tuser = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        m_tready = 1'b0; dig_tready = 1'b0;
        test_reset;
        test_forward;
        test_drop;
        test_overflow;
        test_stall;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
